// File: rtl/spi_master_multi_cs.sv
// SPI master with configurable word width, several active-low chip selects and
// multi-word transactions that keep the selected chip select low between words.
module spi_master_multi_cs #(
    parameter int SPI_MODE          = 0,
    parameter int WORD_WIDTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int NUM_CS            = 2,
    parameter int MAX_WORDS         = 4,
    parameter int CS_INACTIVE_CLKS  = 2,
    localparam int CNT_W            = $clog2(MAX_WORDS + 1),
    localparam int CS_W             = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CNT_W-1:0]      i_TX_Count,
    input  logic [CS_W-1:0]       i_CS_Sel,
    input  logic [WORD_WIDTH-1:0] i_TX_Word,
    input  logic                  i_TX_DV,
    output logic                  o_TX_Ready,
    output logic                  o_RX_DV,
    output logic [WORD_WIDTH-1:0] o_RX_Word,
    output logic [CNT_W-1:0]      o_RX_Count,
    output logic                  o_SPI_clk,
    input  logic                  i_SPI_MISO,
    output logic                  o_SPI_MOSI,
    output logic [NUM_CS-1:0]     o_SPI_CS_n
);

    localparam bit CPOL    = ((SPI_MODE / 2) % 2) == 1;
    localparam bit CPHA    = (SPI_MODE % 2) == 1;
    localparam int EDGES   = 2 * WORD_WIDTH;
    localparam int EDGE_W  = $clog2(EDGES + 1);
    localparam int TMR_MAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, WAIT_WORD, CS_HOLD, CS_GAP} state_t;

    state_t                state, state_nxt;
    logic [TMR_W-1:0]      tmr, tmr_nxt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [CNT_W-1:0]      words_left, word_idx;
    logic [CS_W-1:0]       sel;
    logic [WORD_WIDTH-1:0] tx_shift, rx_shift;
    logic                  accept, first_accept, do_edge, word_done;
    logic                  leading, shift_out, sample;

    // i_TX_Count of 0 means one word; larger than MAX_WORDS clips to MAX_WORDS.
    function automatic logic [CNT_W-1:0] words_total(input logic [CNT_W-1:0] c);
        if (c == '0)                     return CNT_W'(1);
        else if (c > CNT_W'(MAX_WORDS))  return CNT_W'(MAX_WORDS);
        else                             return c;
    endfunction

    // Out-of-range selects drive no line low; the transfer still runs.
    function automatic logic [NUM_CS-1:0] cs_lines(input state_t s, input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        if (s == CS_SETUP || s == XFER || s == WAIT_WORD || s == CS_HOLD)
            for (int i = 0; i < NUM_CS; i++)
                if (idx == CS_W'(i)) v[i] = 1'b0;
        return v;
    endfunction

    assign accept    = i_TX_DV & o_TX_Ready;
    assign leading   = ~edge_cnt[0];
    assign shift_out = do_edge & (CPHA ? leading : ~leading);
    assign sample    = do_edge & (CPHA ? ~leading : leading);

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr + 1'b1;
        first_accept = 1'b0;
        do_edge      = 1'b0;
        word_done    = 1'b0;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (accept) begin
                    first_accept = 1'b1;
                    state_nxt    = CS_SETUP;
                end
            end
            CS_SETUP: begin
                // Preload the half-bit timer so the first SCLK edge follows one cycle later.
                if (tmr == TMR_W'(CLKS_PER_HALF_BIT - 1)) begin
                    state_nxt = XFER;
                    tmr_nxt   = TMR_W'(CLKS_PER_HALF_BIT - 1);
                end
            end
            XFER: begin
                if (edge_cnt == EDGE_W'(EDGES)) begin
                    word_done = 1'b1;
                    tmr_nxt   = '0;
                    state_nxt = (words_left == '0) ? CS_HOLD : WAIT_WORD;
                end else if (tmr == TMR_W'(CLKS_PER_HALF_BIT - 1)) begin
                    do_edge = 1'b1;
                    tmr_nxt = '0;
                end
            end
            WAIT_WORD: begin
                tmr_nxt = '0;
                if (accept) state_nxt = XFER;
            end
            CS_HOLD: begin
                if (tmr == TMR_W'(CLKS_PER_HALF_BIT - 1)) begin
                    state_nxt = CS_GAP;
                    tmr_nxt   = '0;
                end
            end
            CS_GAP: begin
                if (tmr == TMR_W'(CS_INACTIVE_CLKS - 1)) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and all externally visible control/status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            tmr        <= '0;
            edge_cnt   <= '0;
            words_left <= '0;
            word_idx   <= '0;
            sel        <= '0;
            o_TX_Ready <= 1'b0;
            o_RX_DV    <= 1'b0;
            o_RX_Word  <= '0;
            o_RX_Count <= '0;
            o_SPI_clk  <= CPOL;
            o_SPI_MOSI <= 1'b0;
            o_SPI_CS_n <= '1;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            o_TX_Ready <= (state_nxt == IDLE) || (state_nxt == WAIT_WORD);
            o_RX_DV    <= word_done;
            o_SPI_CS_n <= cs_lines(state_nxt, first_accept ? i_CS_Sel : sel);
            if (first_accept) begin
                sel        <= i_CS_Sel;
                words_left <= words_total(i_TX_Count) - 1'b1;
                word_idx   <= '0;
            end else if (accept) begin
                words_left <= words_left - 1'b1;
            end
            if (accept)       edge_cnt <= '0;
            else if (do_edge) edge_cnt <= edge_cnt + 1'b1;
            if (do_edge) o_SPI_clk <= ~o_SPI_clk;
            if (accept && !CPHA) o_SPI_MOSI <= i_TX_Word[WORD_WIDTH-1];
            else if (shift_out)  o_SPI_MOSI <= tx_shift[WORD_WIDTH-1];
            if (word_done) begin
                o_RX_Word  <= rx_shift;
                o_RX_Count <= word_idx;
                word_idx   <= word_idx + 1'b1;
            end
        end
    end

    // Serial shift registers; fully rewritten every word, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (accept)         tx_shift <= CPHA ? i_TX_Word : {i_TX_Word[WORD_WIDTH-2:0], 1'b0};
        else if (shift_out) tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
        if (sample)         rx_shift <= {rx_shift[WORD_WIDTH-2:0], i_SPI_MISO};
    end

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// Directed loopback bench: an 8-bit mode-0 master, an 8-bit mode-3 master and four
// 16-bit masters (one per SPI mode), each with MOSI wired back to MISO.
module tb_spi_master_multi_cs;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // 8-bit, mode 0
    logic [2:0] cnt_m0;  logic sel_m0;  logic [7:0] word_m0;  logic dv_m0;
    logic ready_m0, rxdv_m0, sclk_m0, mosi_m0;
    logic [7:0] rxw_m0;  logic [2:0] rxc_m0;  logic [1:0] cs_m0;

    // 8-bit, mode 3
    logic [2:0] cnt_m3;  logic sel_m3;  logic [7:0] word_m3;  logic dv_m3;
    logic ready_m3, rxdv_m3, sclk_m3, mosi_m3;
    logic [7:0] rxw_m3;  logic [2:0] rxc_m3;  logic [1:0] cs_m3;

    // 16-bit, modes 0..3 with shared stimulus
    logic [2:0] cnt16;  logic sel16;  logic [15:0] word16;  logic dv16;
    logic [3:0] ready16, rxdv16, sclk16, mosi16;
    logic [15:0] rxw16 [4];
    logic [2:0]  rxc16 [4];
    logic [1:0]  cs16  [4];

    spi_master_multi_cs #(.SPI_MODE(0), .WORD_WIDTH(8), .CLKS_PER_HALF_BIT(4), .NUM_CS(2),
                          .MAX_WORDS(4), .CS_INACTIVE_CLKS(2)) u_m0 (
        .i_clk(clk), .i_rst(rst), .i_TX_Count(cnt_m0), .i_CS_Sel(sel_m0), .i_TX_Word(word_m0),
        .i_TX_DV(dv_m0), .o_TX_Ready(ready_m0), .o_RX_DV(rxdv_m0), .o_RX_Word(rxw_m0),
        .o_RX_Count(rxc_m0), .o_SPI_clk(sclk_m0), .i_SPI_MISO(mosi_m0), .o_SPI_MOSI(mosi_m0),
        .o_SPI_CS_n(cs_m0));

    spi_master_multi_cs #(.SPI_MODE(3), .WORD_WIDTH(8), .CLKS_PER_HALF_BIT(4), .NUM_CS(2),
                          .MAX_WORDS(4), .CS_INACTIVE_CLKS(2)) u_m3 (
        .i_clk(clk), .i_rst(rst), .i_TX_Count(cnt_m3), .i_CS_Sel(sel_m3), .i_TX_Word(word_m3),
        .i_TX_DV(dv_m3), .o_TX_Ready(ready_m3), .o_RX_DV(rxdv_m3), .o_RX_Word(rxw_m3),
        .o_RX_Count(rxc_m3), .o_SPI_clk(sclk_m3), .i_SPI_MISO(mosi_m3), .o_SPI_MOSI(mosi_m3),
        .o_SPI_CS_n(cs_m3));

    for (genvar g = 0; g < 4; g++) begin : g16
        spi_master_multi_cs #(.SPI_MODE(g), .WORD_WIDTH(16), .CLKS_PER_HALF_BIT(4), .NUM_CS(2),
                              .MAX_WORDS(4), .CS_INACTIVE_CLKS(2)) u (
            .i_clk(clk), .i_rst(rst), .i_TX_Count(cnt16), .i_CS_Sel(sel16), .i_TX_Word(word16),
            .i_TX_DV(dv16), .o_TX_Ready(ready16[g]), .o_RX_DV(rxdv16[g]), .o_RX_Word(rxw16[g]),
            .o_RX_Count(rxc16[g]), .o_SPI_clk(sclk16[g]), .i_SPI_MISO(mosi16[g]),
            .o_SPI_MOSI(mosi16[g]), .o_SPI_CS_n(cs16[g]));
    end

    // Event monitors: free-running counters, the stimulus block works with differences.
    int dvcnt_m0 = 0, edges_m0 = 0, run_m0 = 0, last_gap_m0 = 0;
    logic sclk_prev_m0 = 1'b0;
    int cs1_rise_m3 = 0, cs0_low_m3 = 0;
    logic [1:0] cs_prev_m3 = 2'b11;
    logic [7:0] q3w[$];
    logic [2:0] q3c[$];
    int edges16 [4] = '{0, 0, 0, 0};
    logic [3:0] sclk_prev16 = 4'b1100;

    always @(posedge clk) begin
        sclk_prev_m0 <= sclk_m0;
        if (sclk_m0 != sclk_prev_m0) edges_m0 <= edges_m0 + 1;
        if (rxdv_m0) dvcnt_m0 <= dvcnt_m0 + 1;
        if (cs_m0 == 2'b11) run_m0 <= run_m0 + 1;
        else begin
            if (run_m0 != 0) last_gap_m0 <= run_m0;
            run_m0 <= 0;
        end
    end

    always @(posedge clk) begin
        cs_prev_m3 <= cs_m3;
        if (cs_m3[1] && !cs_prev_m3[1]) cs1_rise_m3 <= cs1_rise_m3 + 1;
        if (!cs_m3[0]) cs0_low_m3 <= cs0_low_m3 + 1;
        if (rxdv_m3) begin
            q3w.push_back(rxw_m3);
            q3c.push_back(rxc_m3);
        end
    end

    always @(posedge clk) begin
        sclk_prev16 <= sclk16;
        for (int i = 0; i < 4; i++)
            if (sclk16[i] != sclk_prev16[i]) edges16[i] <= edges16[i] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_m0(input logic [7:0] w, input logic [2:0] c, input logic s);
        int n = 0;
        while (!ready_m0 && n < 600) begin tick(1); n++; end
        chk("m0_ready_wait", ready_m0, 1);
        word_m0 = w; cnt_m0 = c; sel_m0 = s; dv_m0 = 1'b1;
        tick(1);
        dv_m0 = 1'b0;
    endtask

    task automatic send_m3(input logic [7:0] w, input logic [2:0] c, input logic s);
        int n = 0;
        while (!ready_m3 && n < 600) begin tick(1); n++; end
        chk("m3_ready_wait", ready_m3, 1);
        word_m3 = w; cnt_m3 = c; sel_m3 = s; dv_m3 = 1'b1;
        tick(1);
        dv_m3 = 1'b0;
    endtask

    task automatic wait_dv_m0();
        int n = 0;
        while (!rxdv_m0 && n < 600) begin tick(1); n++; end
        chk("m0_dv_wait", rxdv_m0, 1);
    endtask

    initial begin
        int d0, e0, n;
        int e16 [4];
        rst = 1'b1;
        dv_m0 = 0; word_m0 = 0; cnt_m0 = 0; sel_m0 = 0;
        dv_m3 = 0; word_m3 = 0; cnt_m3 = 0; sel_m3 = 0;
        dv16 = 0;  word16 = 0;  cnt16 = 0;  sel16 = 0;
        tick(3);

        // Reset values
        chk("rst_sclk_m0", sclk_m0, 0);
        chk("rst_cs_m0", cs_m0, 2'b11);
        chk("rst_mosi_m0", mosi_m0, 0);
        chk("rst_ready_m0", ready_m0, 0);
        chk("rst_rxdv_m0", rxdv_m0, 0);
        chk("rst_rxw_m0", rxw_m0, 8'h00);
        chk("rst_rxc_m0", rxc_m0, 3'd0);
        chk("rst_sclk_m3", sclk_m3, 1);
        chk("rst_cs_m3", cs_m3, 2'b11);
        chk("rst_sclk16", sclk16, 4'b1100);
        rst = 1'b0;
        chk("rel_ready_low", ready_m0, 0);
        tick(1);
        chk("rel_ready_high", ready_m0, 1);

        // Test 1: mode 0, single word 0xC1 on CS0
        d0 = dvcnt_m0; e0 = edges_m0;
        send_m0(8'hC1, 3'd1, 1'b0);
        chk("t1_ready_drop", ready_m0, 0);
        chk("t1_cs_low", cs_m0, 2'b10);
        tick(4);
        chk("t1_pre_edge_sclk", sclk_m0, 0);
        tick(1);
        chk("t1_first_edge_sclk", sclk_m0, 1);
        chk("t1_mosi_msb", mosi_m0, 1);
        wait_dv_m0();
        chk("t1_rx_word", rxw_m0, 8'hC1);
        chk("t1_rx_count", rxc_m0, 3'd0);
        chk("t1_cs_at_dv", cs_m0, 2'b10);
        chk("t1_edges", edges_m0 - e0, 16);
        chk("t1_ready_at_dv", ready_m0, 0);
        tick(1);
        chk("t1_dv_one_cycle", rxdv_m0, 0);
        tick(2);
        chk("t1_cs_hold", cs_m0, 2'b10);
        tick(1);
        chk("t1_cs_release", cs_m0, 2'b11);
        tick(2);
        chk("t1_ready_back", ready_m0, 1);
        chk("t1_dv_total", dvcnt_m0 - d0, 1);
        chk("t1_rx_hold", rxw_m0, 8'hC1);

        // Test 2: mode 3, three words on CS1; later count/sel inputs must be ignored
        send_m3(8'hBE, 3'd3, 1'b1);
        chk("t2_cs_low", cs_m3, 2'b01);
        chk("t2_sclk_idle", sclk_m3, 1);
        send_m3(8'hEF, 3'd0, 1'b0);
        send_m3(8'h5A, 3'd0, 1'b0);
        n = 0;
        while (q3w.size() < 3 && n < 800) begin tick(1); n++; end
        chk("t2_dv_count", q3w.size(), 3);
        chk("t2_rx0", q3w[0], 8'hBE);
        chk("t2_rx1", q3w[1], 8'hEF);
        chk("t2_rx2", q3w[2], 8'h5A);
        chk("t2_cnt0", q3c[0], 3'd0);
        chk("t2_cnt1", q3c[1], 3'd1);
        chk("t2_cnt2", q3c[2], 3'd2);
        chk("t2_cs1_no_rise", cs1_rise_m3, 0);
        chk("t2_cs_still_low", cs_m3, 2'b01);
        tick(40);
        chk("t2_cs_released", cs_m3, 2'b11);
        chk("t2_cs0_never_low", cs0_low_m3, 0);
        chk("t2_no_extra_dv", q3w.size(), 3);
        chk("t2_sclk_idle_end", sclk_m3, 1);

        // Test 3: 16-bit word 0xA55A in all four modes, SCLK period of 8 clocks
        for (int i = 0; i < 4; i++) e16[i] = edges16[i];
        word16 = 16'hA55A; cnt16 = 3'd1; sel16 = 1'b0; dv16 = 1'b1;
        tick(1);
        dv16 = 1'b0;
        chk("t3_sclk_idle", sclk16, 4'b1100);
        tick(4);
        chk("t3_sclk_pre_edge", sclk16, 4'b1100);
        tick(1);
        chk("t3_sclk_edge1", sclk16, 4'b0011);
        tick(3);
        chk("t3_sclk_hold", sclk16, 4'b0011);
        tick(1);
        chk("t3_sclk_edge2", sclk16, 4'b1100);
        n = 0;
        while (!rxdv16[0] && n < 600) begin tick(1); n++; end
        chk("t3_dv_all", rxdv16, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rx_mode%0d", i), rxw16[i], 16'hA55A);
            chk($sformatf("t3_edges_mode%0d", i), edges16[i] - e16[i], 32);
        end
        chk("t3_sclk_idle_end", sclk16, 4'b1100);

        // Test 4: DV held high across the transfer, count 0 means one word
        n = 0;
        while (!ready_m0 && n < 600) begin tick(1); n++; end
        d0 = dvcnt_m0; e0 = edges_m0;
        word_m0 = 8'h96; cnt_m0 = 3'd0; sel_m0 = 1'b0; dv_m0 = 1'b1;
        tick(1);
        word_m0 = 8'h00;
        wait_dv_m0();
        dv_m0 = 1'b0;
        chk("t4_rx_word", rxw_m0, 8'h96);
        chk("t4_rx_count", rxc_m0, 3'd0);
        tick(20);
        chk("t4_dv_total", dvcnt_m0 - d0, 1);
        chk("t4_edges", edges_m0 - e0, 16);
        chk("t4_ready", ready_m0, 1);
        chk("t4_cs", cs_m0, 2'b11);

        // Test 5: reset after five SCLK edges, then a clean transfer
        d0 = dvcnt_m0; e0 = edges_m0;
        send_m0(8'hF0, 3'd1, 1'b0);
        n = 0;
        while ((edges_m0 - e0) < 5 && n < 600) begin tick(1); n++; end
        chk("t5_edges_before_rst", edges_m0 - e0, 5);
        rst = 1'b1;
        #1;
        chk("t5_rst_cs", cs_m0, 2'b11);
        chk("t5_rst_sclk", sclk_m0, 0);
        chk("t5_rst_ready", ready_m0, 0);
        chk("t5_rst_mosi", mosi_m0, 0);
        tick(2);
        rst = 1'b0;
        tick(60);
        chk("t5_no_dv", dvcnt_m0 - d0, 0);
        chk("t5_rxw_reset", rxw_m0, 8'h00);
        send_m0(8'h3C, 3'd1, 1'b0);
        wait_dv_m0();
        chk("t5_rx_word", rxw_m0, 8'h3C);

        // Test 6: back-to-back transactions keep CS high for at least two clocks
        send_m0(8'h11, 3'd1, 1'b0);
        wait_dv_m0();
        chk("t6_rx_first", rxw_m0, 8'h11);
        send_m0(8'h22, 3'd1, 1'b0);
        chk("t6_cs_low_again", cs_m0, 2'b10);
        tick(1);
        chk("t6_gap_min", last_gap_m0 >= 2, 1);
        wait_dv_m0();
        chk("t6_rx_second", rxw_m0, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
